// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-only data memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module load_store_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [MEM_IDX_W-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e               state_q;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic [31:0]          wdata_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic [31:0]          resp_rdata_q;
  logic                 resp_err_q;
  logic [MEM_IDX_W-1:0] mem_addr_q;
  logic [31:0]          mem_wdata_q;
  logic                 mem_we_q;

  logic illegal;
  logic misalign;
  logic unused_addr_hi;

  // Upper address bits select nothing: the word index wraps.
  assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (f3[1:0])
      2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'b0;
      mem_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (illegal || misalign) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'b0;
            end else begin
              mem_addr_q <= req_addr[MEM_IDX_W+1:2];
              if (req_we && req_funct3 == 3'b010) begin
                state_q     <= StWr;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (!we_q) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_ext(mem_rdata, funct3_q, off_q);
          end else begin
            state_q     <= StWr;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= store_merge(mem_rdata, wdata_q, funct3_q, off_q);
          end
        end
        StWr: begin
          state_q      <= StResp;
          mem_we_q     <= 1'b0;
          mem_wdata_q  <= 32'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'b0;
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // A reset edge must never commit a write.
  assign mem_we     = mem_we_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model, random and directed requests.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32), .MEM_IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] t;
    logic [31:0] lat;
  } exp_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  exp_t        sq[$];
  wr_t         wq[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] cyc = 0;
  logic [31:0] mem[16];
  logic [31:0] init_mem[16];
  logic [7:0]  ref_bytes[64];
  bit          preload = 1'b1;
  int          ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       resp_ready = 1'($urandom_range(0, 1));
      2:       resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  // Reference model: byte-addressed memory, requests resolved in one step.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] t);
    exp_t        e;
    wr_t         w;
    int          idx, size, off;
    bit          err;
    logic [31:0] v;
    idx  = int'((addr >> 2) % 16);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
    if (!err && size > 1 && (addr % size) != 0) err = 1'b1;
`endif
    off = int'(addr % 4);
    off = off - (off % size);
    e.t = t;
    if (err) begin
      e.rdata = 32'b0;
      e.err   = 1'b1;
      e.lat   = 1;
    end else if (!we) begin
      v = 32'b0;
      for (int k = 0; k < size; k++) v |= 32'(ref_bytes[idx*4+off+k]) << (8 * k);
      if (!f3[2] && v[8*size-1]) v |= 32'hFFFF_FFFF << (8 * size);
      e.rdata = (size == 4) ? v : v;
      e.err   = 1'b0;
      e.lat   = 2;
    end else begin
      for (int k = 0; k < size; k++) ref_bytes[idx*4+off+k] = wd[8*k +: 8];
      e.rdata = 32'b0;
      e.err   = 1'b0;
      e.lat   = (size == 4) ? 2 : 3;
      w.idx   = 4'(idx);
      w.data  = ref_word(idx);
      w.cyc   = t + e.lat - 1;
      wq.push_back(w);
    end
    sq.push_back(e);
  endtask

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    bit          accepted;
    logic [31:0] t;
    accepted   = 1'b0;
    t          = 0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        t        = cyc;
        break;
      end
    end
    if (!accepted) begin
      chk("req_accept_timeout", 32'(accepted), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (track) model(we, f3, addr, wd, t);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sq.size() == 0 && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] held_rdata = 32'b0;
  logic        held_err = 1'b0;
  logic [31:0] rise = 0;

  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      chk("valid_ready_exclusive", 32'(resp_valid & req_ready), 32'd0);
      if (mem_we) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got idx %0d data 0x%08h expected no write", mem_addr,
                   mem_wdata);
        end else begin
          w = wq.pop_front();
          chk("write_idx", 32'(mem_addr), 32'(w.idx));
          chk("write_data", mem_wdata, w.data);
          chk("write_cycle", cyc, w.cyc);
        end
      end
      if (resp_valid && !prev_valid) rise = cyc;
      if (prev_hold) begin
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, held_rdata);
        chk("hold_err", 32'(resp_err), 32'(held_err));
        chk("hold_no_mem_we", 32'(mem_we), 32'd0);
      end
      if (resp_valid && resp_ready) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got rdata 0x%08h err %0d expected none", resp_rdata,
                   resp_err);
        end else begin
          e = sq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", rise - e.t, e.lat);
        end
      end
      prev_hold  = resp_valid && !resp_ready;
      held_rdata = resp_rdata;
      held_err   = resp_err;
      prev_valid = resp_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
    init_mem[3] = 32'h8899_AABB;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) ref_bytes[i*4+k] = init_mem[i][8*k +: 8];

    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;

    // Directed sequence
    issue(1'b0, 3'b000, 32'h0D, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h0D, 32'h0, 1'b1);
    issue(1'b0, 3'b101, 32'h0E, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h0C, 32'h0, 1'b1);
    issue(1'b1, 3'b000, 32'h0C, 32'h1234_5677, 1'b1);
    issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1);
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'h12, 32'h0000_1234, 1'b1);
    wait_idle();
    chk("word3_after_sb", mem[3], 32'h8899_AA77);
    chk("word4_after_sh", mem[4], 32'h1234_BEEF);

    ready_mode = 2;
    issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    wait_idle();

    issue(1'b0, 3'b111, 32'h0C, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h0C, 32'h55, 1'b1);
    issue(1'b0, 3'b010, 32'h0E, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h4D, 32'h0, 1'b1);
    wait_idle();

    // Reset while the SB write is pending
    issue(1'b1, 3'b000, 32'h0C, 32'hFFFF_FF00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gates_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_word3", mem[3], ref_word(3));
    @(posedge clk);
    #1;

    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
            $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(sq.size()), 32'd0);
    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath (ALU address + rs2 data + funct3) and the word-only data memory.
- Converts byte-addressed RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores use a read-modify-write sequence, because the memory only supports whole-word writes.
- Loads are sign/zero-extended; valid/ready handshakes on both the request and response sides.

Parameters:
- ADDR_W, 32, width of the byte address from the datapath.
- MEM_IDX_W, 4, width of the word index driven to data memory (word index = byte addr[MEM_IDX_W+1:2]).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (low bits used for B/H).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3 (or misalignment, see Optional Feature).
- mem_addr  out  MEM_IDX_W  word index to data memory.
- mem_wdata  out  32  merged write word; 0 when mem_we=0.
- mem_we  out  1  memory write enable (1 = write, 0 = read).
- mem_rdata  in  32  combinational read data for mem_addr, valid when mem_we=0.

Behaviour:
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. All request and buffer registers are cleared.
- FSM states: IDLE, RD, WR, RESP. Outputs decode from state and latched registers only.
- IDLE: req_ready=1. On req_valid=1, latch we/funct3/addr/wdata, then transition:
  - load -> RD
  - SW -> WR
  - SB/SH -> RD
  - illegal funct3 (011, 110, 111; also 100/101 with we=1) -> RESP with err=1 and no memory access.
- RD: mem_addr=word index, mem_we=0. Capture mem_rdata into rbuf at the clock edge. Load -> RESP; SB/SH -> WR.
- WR: mem_we=1 for exactly one cycle. mem_wdata is:
  - SW: wdata.
  - SB: rbuf with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rbuf with halfword lane addr[1] replaced by wdata[15:0].
  - Then -> RESP.
- RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_ready=1, then -> IDLE. resp_valid and req_ready are never high together.
- Load extraction from rbuf:
  - B/BU: lane addr[1:0].
  - H/HU: lane addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Latency, with acceptance edge T:
  - load: resp_valid from T+2.
  - SW: mem_we in cycle T+1, resp_valid T+2.
  - SB/SH: RD T+1, WR T+2, resp_valid T+3.
- Back-to-back: the next request is accepted in the cycle after the RESP handshake.
- Reset mid-operation: mem_we is gated by ~rst, so no write is committed on a reset edge. State returns to IDLE and any pending response is discarded.
- Address bits above MEM_IDX_W+1 are ignored, so the index wraps modulo 2^MEM_IDX_W.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: in IDLE, H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, go directly to RESP with resp_err=1, resp_rdata=0, and no memory access.
- Undefined: no check. Halfword uses addr[1] only; word ignores addr[1:0]; resp_err is raised only for illegal funct3.

Test Plan:
- Preload word3=0x8899AABB. LB addr 0x0D -> resp_rdata 0xFFFFFFAA at T+2, resp_err=0; LBU same addr -> 0x000000AA.
- LHU addr 0x0E -> 0x00008899; LH addr 0x0C -> 0xFFFFAABB.
- SB addr 0x0C wdata 0x12345677 -> mem_we high only in cycle T+2 with mem_wdata 0x8899AA77. Then LW 0x0C -> 0x8899AA77.
- SW addr 0x10 wdata 0xDEADBEEF -> mem_we in T+1, resp at T+2; LW 0x10 -> 0xDEADBEEF. SH addr 0x12 wdata 0x00001234 -> word4=0x1234BEEF.
- Hold resp_ready=0 for 3 cycles -> resp_valid stays 1, resp_rdata stable, req_ready=0, no memory activity.
- Assert rst during WR of SB 0x0C -> word3 unchanged, IDLE next cycle. funct3=111 -> resp_err=1, no access. With LSU_MISALIGN_CHECK_EN, LW 0x0E -> resp_err=1 and mem_we never set.
